// File: rtl/sevenseg_digit_mux.sv
// Four-digit multiplexed seven-segment driver.
// Follows an external 2-bit digit counter, blanks all anodes for a fixed
// interval after every digit change, and decodes the digit from a per-frame
// snapshot of the display value so a frame never mixes two values.

// Property checker: at most one anode may be lit at any time.
module sevenseg_digit_mux_chk #(
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input logic       clk,
  input logic       reset,
  input logic [3:0] an
);

  logic [3:0] an_lit_s;

  assign an_lit_s = ANODE_ACTIVE_LOW ? ~an : an;

  an_onehot0_a: assert property (@(posedge clk) disable iff (reset) $onehot0(an_lit_s));

endmodule

module sevenseg_digit_mux #(
  parameter int unsigned BLANK_CYCLES     = 4,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  // Counter just wide enough to hold BLANK_CYCLES-1.
  localparam int unsigned CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Electrical "off" levels for each output group.
  localparam logic [3:0] AN_OFF  = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Hex digit to active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Nibble idx of a 16-bit value.
  function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      2'd3:    n = v[15:12];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // True when digit idx is a leading zero that should be suppressed.
  function automatic logic lz_hide(input logic [15:0] v, input logic lz, input logic [1:0] idx);
    logic h;
    case (idx)
      2'd0:    h = 1'b0;
      2'd1:    h = lz && (v[15:4] == 12'h000);
      2'd2:    h = lz && (v[15:8] == 8'h00);
      2'd3:    h = lz && (v[15:12] == 4'h0);
      default: h = 1'b0;
    endcase
    return h;
  endfunction

  // Anode pattern lighting only digit idx.
  function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ANODE_ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  // Convert an active-high segment vector to the bus polarity.
  function automatic logic [6:0] seg_level(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // Convert an active-high decimal-point request to the bus polarity.
  function automatic logic dp_level(input logic d);
    return SEG_ACTIVE_LOW ? ~d : d;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [1:0]      sel_q_r, sel_nxt_s;
  logic            started_r;
  logic [15:0]     snap_value_r, snap_value_nxt_s;
  logic [3:0]      snap_dp_r, snap_dp_nxt_s;
  logic            snap_lz_r, snap_lz_nxt_s;
  logic [3:0]      an_r, an_nxt_s;
  logic [6:0]      seg_r, seg_nxt_s;
  logic            dp_r, dp_nxt_s;
  logic            frame_done_r, frame_done_nxt_s;

  logic            change_s;
  logic [15:0]     src_value_s;
  logic [3:0]      src_dp_s;
  logic            src_lz_s;
  logic [3:0]      nib_s;

  // Digit 0 entering DRIVE decodes the fresh inputs (they are being captured
  // on that very edge); every other digit decodes the held snapshot.
  always_comb begin
    src_value_s = snap_value_r;
    src_dp_s    = snap_dp_r;
    src_lz_s    = snap_lz_r;
    if (sel_q_r == 2'd0) begin
      src_value_s = value;
      src_dp_s    = dp_en;
      src_lz_s    = lz_blank;
    end else begin
      src_value_s = snap_value_r;
      src_dp_s    = snap_dp_r;
      src_lz_s    = snap_lz_r;
    end
    nib_s = nibble_of(src_value_s, sel_q_r);
  end

  // The first edge after reset release is treated like a digit change so the
  // full blanking interval is counted from that edge.
  assign change_s = (digit_sel != sel_q_r) || !started_r;

  // Next-state and next-output logic for the BLANK/DRIVE controller.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    sel_nxt_s        = sel_q_r;
    snap_value_nxt_s = snap_value_r;
    snap_dp_nxt_s    = snap_dp_r;
    snap_lz_nxt_s    = snap_lz_r;
    an_nxt_s         = an_r;
    seg_nxt_s        = seg_r;
    dp_nxt_s         = dp_r;
    frame_done_nxt_s = 1'b0;

    if (change_s) begin
      sel_nxt_s   = digit_sel;
      cnt_nxt_s   = CNT_ZERO;
      state_nxt_s = ST_BLANK;
      an_nxt_s    = AN_OFF;
      seg_nxt_s   = SEG_OFF;
      dp_nxt_s    = DP_OFF;
    end else begin
      case (state_r)
        ST_BLANK: begin
          an_nxt_s  = AN_OFF;
          seg_nxt_s = SEG_OFF;
          dp_nxt_s  = DP_OFF;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_DRIVE;
            if (sel_q_r == 2'd0) begin
              snap_value_nxt_s = value;
              snap_dp_nxt_s    = dp_en;
              snap_lz_nxt_s    = lz_blank;
            end else begin
              snap_value_nxt_s = snap_value_r;
              snap_dp_nxt_s    = snap_dp_r;
              snap_lz_nxt_s    = snap_lz_r;
            end
            an_nxt_s = anode_pattern(sel_q_r);
            if (lz_hide(src_value_s, src_lz_s, sel_q_r)) begin
              seg_nxt_s = SEG_OFF;
            end else begin
              seg_nxt_s = seg_level(hex_decode(nib_s));
            end
            dp_nxt_s         = dp_level(src_dp_s[sel_q_r]);
            frame_done_nxt_s = (sel_q_r == 2'd3);
          end else if (cnt_r < CNT_LAST) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_DRIVE: begin
          state_nxt_s = ST_DRIVE;
        end
        default: begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = CNT_ZERO;
          an_nxt_s    = AN_OFF;
          seg_nxt_s   = SEG_OFF;
          dp_nxt_s    = DP_OFF;
        end
      endcase
    end
  end

  // Controller state, blanking counter, tracked digit and frame snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_BLANK;
      cnt_r        <= CNT_ZERO;
      sel_q_r      <= 2'd0;
      started_r    <= 1'b0;
      snap_value_r <= 16'h0000;
      snap_dp_r    <= 4'h0;
      snap_lz_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      sel_q_r      <= sel_nxt_s;
      started_r    <= 1'b1;
      snap_value_r <= snap_value_nxt_s;
      snap_dp_r    <= snap_dp_nxt_s;
      snap_lz_r    <= snap_lz_nxt_s;
    end
  end

  // Registered display outputs; reset forces them dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r         <= AN_OFF;
      seg_r        <= SEG_OFF;
      dp_r         <= DP_OFF;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_done = frame_done_r;

  sevenseg_digit_mux_chk #(
    .ANODE_ACTIVE_LOW(ANODE_ACTIVE_LOW)
  ) u_chk (
    .clk  (clk),
    .reset(reset),
    .an   (an_r)
  );

endmodule

// File: tb/tb_sevenseg_digit_mux.sv
// Scoreboard bench for sevenseg_digit_mux (default parameters).
// The stimulus side runs a reference model per clock edge and queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_sevenseg_digit_mux;

  localparam int B = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } out_t;

  localparam out_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  digit_sel;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int fd_count = 0;

  out_t exp_q[$];
  out_t mon_e;

  logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: edges since the last digit change, current digit,
  // and the frame snapshot taken when digit 0 lights up.
  int          m_age;
  logic [1:0]  m_cur;
  bit          m_started;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  bit          m_lz;

  always #5 clk = ~clk;

  sevenseg_digit_mux dut (
    .clk       (clk),
    .reset     (reset),
    .digit_sel (digit_sel),
    .value     (value),
    .dp_en     (dp_en),
    .lz_blank  (lz_blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  // Expected outputs after the coming clock edge, given the current inputs.
  function automatic out_t model_edge();
    out_t        o;
    logic [15:0] upper;
    logic [3:0]  nib;
    o = OFF;
    if (reset) begin
      m_started = 1'b0;
      m_age     = 0;
      m_cur     = 2'd0;
      m_val     = 16'h0000;
      m_dp      = 4'h0;
      m_lz      = 1'b0;
      return o;
    end
    if (!m_started || digit_sel != m_cur) begin
      m_started = 1'b1;
      m_cur     = digit_sel;
      m_age     = 0;
    end else if (m_age < 1000) begin
      m_age++;
    end
    if (m_age < B) return o;
    if (m_age == B && m_cur == 2'd0) begin
      m_val = value;
      m_dp  = dp_en;
      m_lz  = lz_blank;
    end
    upper = m_val >> (4 * int'(m_cur));
    nib   = upper[3:0];
    o.an  = ~(4'b0001 << m_cur);
    if (m_lz && m_cur != 2'd0 && upper == 16'h0000) o.seg = 7'h7F;
    else o.seg = ~dec_tbl[nib];
    o.dp = ~m_dp[m_cur];
    o.fd = (m_age == B && m_cur == 2'd3);
    return o;
  endfunction

  task automatic step();
    out_t e;
    e = model_edge();
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic show(input logic [1:0] s, input int n);
    digit_sel = s;
    hold(n);
  endtask

  // Assert reset away from any edge and check the outputs go dark at once.
  task automatic apply_reset();
    #5;
    reset = 1'b1;
    #1;
    tests++;
    if ({an, seg, dp, frame_done} !== OFF) begin
      fails++;
      $display("FAIL async_reset an=%h seg=%h dp=%b fd=%b, wanted an=F seg=7F dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    #4;
    hold(2);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] pick_value();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: return r & 16'h000F;
      1: return r & 16'h00FF;
      2: return r & 16'h0FFF;
      3: return 16'h0000;
      default: return r;
    endcase
  endfunction

  // Monitor: compare every queued expectation with what the DUT shows.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if ({an, seg, dp, frame_done} !== mon_e) begin
        fails++;
        $display("FAIL outputs t=%0t got an=%h seg=%h dp=%b fd=%b, wanted an=%h seg=%h dp=%b fd=%b",
                 $time, an, seg, dp, frame_done, mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
      end
    end
  end

  initial begin
    int fd_base;
    int sel_i;
    reset     = 1'b1;
    digit_sel = 2'd0;
    value     = 16'h1234;
    dp_en     = 4'h0;
    lz_blank  = 1'b0;
    #1;
    hold(2);
    reset = 1'b0;

    // Digits 0..3 of 1234, then value changes mid-frame.
    show(2'd0, 16);
    show(2'd1, 16);
    show(2'd2, 8);
    value = 16'hABCD;
    hold(8);
    show(2'd3, 16);
    show(2'd0, 16);
    show(2'd1, 6);

    // Reset in the middle of a driven digit, then recover on digit 0.
    apply_reset();
    show(2'd0, 8);

    // Leading-zero blanking on and off, with decimal points.
    value    = 16'h0007;
    dp_en    = 4'b1010;
    lz_blank = 1'b1;
    for (int i = 0; i < 4; i++) show(2'(i), 8);
    lz_blank = 1'b0;
    for (int i = 0; i < 4; i++) show(2'(i), 8);

    // Two changes two cycles apart: one longer blank, digit 1 never shown.
    show(2'd0, 8);
    show(2'd1, 2);
    show(2'd2, 10);

    // Three full frames -> three frame_done pulses.
    fd_base = fd_count;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) show(2'(i), 8);
    end
    hold(1);
    tests++;
    if (fd_count - fd_base != 3) begin
      fails++;
      $display("FAIL frame_done_count got %0d, wanted 3", fd_count - fd_base);
    end

    // Randomised digit walks, out-of-order jumps and value churn.
    sel_i = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) < 3) sel_i = (sel_i + 1) % 4;
      else sel_i = int'($urandom_range(0, 3));
      digit_sel = 2'(sel_i);
      dp_en     = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lz_blank = ~lz_blank;
      for (int j = 0; j < int'($urandom_range(1, 12)); j++) begin
        if ($urandom_range(0, 7) == 0) value = pick_value();
        step();
      end
    end

    // Let the monitor drain the last expectation.
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain %0d expectations left, wanted 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
